// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INCR           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_STOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs; flush empties it in one cycle.
module fetch_queue
  import if_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  fetch_entry_t mem_r [QDEPTH];

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head  = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer update
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push && !full) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop && !empty) rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < QDEPTH; i++) mem_r[i] <= '0;
    end else if (push && !full && !flush) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_entry;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage producer: PC generation, single-outstanding imem reads, fetch queue, IF/ID outputs.
// Define FETCH_ALIGN_CHECK_EN to add misalign_err and halt on misaligned redirect targets.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] STOP_INST = DEFAULT_STOP_INST
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] inst_IF_out,
  output logic        stop_out,
  output logic        valid_out
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  fetch_state_e state_r;
  logic [31:0]  fetch_pc_r;
  logic         drop_r;
  logic         drop_halt_r;
  logic [31:0]  redir_pc_s;
  logic         redir_halt_s;
  logic         push_s;
  logic         pop_s;
  logic         full_s;
  logic         empty_s;
  fetch_entry_t push_entry_s;
  fetch_entry_t head_s;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_pc_s   = redirect_pc;
  assign redir_halt_s = (redirect_pc[1:0] != 2'b00);

  // Sticky misaligned-redirect flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      misalign_err <= 1'b0;
    end else if (redirect_valid && redir_halt_s) begin
      misalign_err <= 1'b1;
    end
  end
`else
  logic unused_pc_bits_s;
  assign redir_pc_s       = {redirect_pc[31:2], 2'b00};
  assign redir_halt_s     = 1'b0;
  assign unused_pc_bits_s = ^redirect_pc[1:0];
`endif

  // A redirect discards both a coincident ack and any ack of a dropped request.
  assign push_s       = imem_ack && imem_req && !drop_r && !redirect_valid;
  assign pop_s        = !stall_in && !empty_s && !redirect_valid;
  assign push_entry_s = {imem_addr, imem_rdata};

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_s),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .push_entry(push_entry_s),
    .full      (full_s),
    .empty     (empty_s),
    .head      (head_s)
  );

  // Fetch FSM and memory request interface
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= FETCH;
      fetch_pc_r  <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      drop_r      <= 1'b0;
      drop_halt_r <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_r <= redir_pc_s;
      if (imem_req && !imem_ack) begin
        // The handshake must still complete; its data is thrown away on arrival.
        drop_r      <= 1'b1;
        drop_halt_r <= redir_halt_s;
        state_r     <= WAIT;
      end else begin
        imem_req    <= 1'b0;
        drop_r      <= 1'b0;
        drop_halt_r <= 1'b0;
        state_r     <= redir_halt_s ? HALT : FETCH;
      end
    end else begin
      case (state_r)
        FETCH: begin
          if (!full_s) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc_r;
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            if (drop_r) begin
              drop_r      <= 1'b0;
              drop_halt_r <= 1'b0;
              state_r     <= drop_halt_r ? HALT : FETCH;
            end else begin
              fetch_pc_r <= fetch_pc_r + PC_INCR;
              state_r    <= (imem_rdata == STOP_INST) ? HALT : FETCH;
            end
          end
        end
        HALT: begin
          imem_req <= 1'b0;
        end
        default: begin
          imem_req <= 1'b0;
          state_r  <= FETCH;
        end
      endcase
    end
  end

  // IF/ID output register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      PC_out      <= 32'h0000_0000;
      inst_IF_out <= 32'h0000_0000;
      stop_out    <= 1'b0;
      valid_out   <= 1'b0;
    end else if (redirect_valid) begin
      inst_IF_out <= 32'h0000_0000;
      stop_out    <= 1'b0;
      valid_out   <= 1'b0;
    end else if (!stall_in) begin
      if (!empty_s) begin
        PC_out      <= head_s.pc;
        inst_IF_out <= head_s.inst;
        valid_out   <= 1'b1;
        if (head_s.inst == STOP_INST) stop_out <= 1'b1;
      end else begin
        inst_IF_out <= 32'h0000_0000;
        valid_out   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by randomized stall/redirect/latency.
module tb_if_fetch_unit;

  localparam logic [31:0] STOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic [31:0] inst_IF_out;
  logic        stop_out;
  logic        valid_out;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  // memory environment
  int          lat      = 1;
  int          mem_cnt  = 0;
  bit          rand_lat = 1'b0;
  logic [31:0] stop_addr = 32'hFFFF_FFF0;
  logic [31:0] req_addr_seen;

  // reference model state
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  logic        stop_seen;
  logic        req_halted;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall_in      (stall_in),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .PC_out        (PC_out),
    .inst_IF_out   (inst_IF_out),
    .stop_out      (stop_out),
    .valid_out     (valid_out)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == stop_addr) return STOP;
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_0113;
      default: return (a * 32'h9E37_79B1) | 32'h1;
    endcase
  endfunction

  // instruction memory: acks 'lat' cycles after the request is first seen, address must stay put
  always @(negedge clk) begin
    if (!rstn) begin
      imem_ack = 1'b0;
      mem_cnt  = 0;
    end else if (imem_ack) begin
      imem_ack = 1'b0;
      mem_cnt  = 0;
    end else if (imem_req) begin
      if (mem_cnt == 0) begin
        req_addr_seen = imem_addr;
        if (rand_lat) lat = $urandom_range(1, 3);
      end else begin
        check("addr_stable", imem_addr, req_addr_seen);
      end
      mem_cnt++;
      if (mem_cnt > lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end
    end
  end

  // One clock; then compare outputs against the program-order model.
  task automatic step();
    logic        r, s, p_stop, p_valid, p_req;
    logic [31:0] rpc, raw_pc, p_pc, p_inst;
    r = redirect_valid; s = stall_in; raw_pc = redirect_pc;
    rpc = redirect_pc & 32'hFFFF_FFFC;
    p_pc = PC_out; p_inst = inst_IF_out; p_stop = stop_out; p_valid = valid_out; p_req = imem_req;
    @(posedge clk);
    #1;
    if (r) begin
      check1("redir_valid", valid_out, 1'b0);
      check("redir_inst", inst_IF_out, 32'h0);
      check1("redir_stop", stop_out, 1'b0);
      check("redir_pc_hold", PC_out, p_pc);
      exp_pc = rpc; exp_req = rpc; stop_seen = 1'b0; req_halted = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (raw_pc[1:0] != 2'b00) req_halted = 1'b1;
`endif
    end else if (s) begin
      check("stall_pc", PC_out, p_pc);
      check("stall_inst", inst_IF_out, p_inst);
      check1("stall_stop", stop_out, p_stop);
      check1("stall_valid", valid_out, p_valid);
    end else if (valid_out) begin
      check("pop_pc", PC_out, exp_pc);
      check("pop_inst", inst_IF_out, mem_word(exp_pc));
      check1("pop_after_stop", stop_seen, 1'b0);
      if (mem_word(exp_pc) == STOP) stop_seen = 1'b1;
      check1("pop_stop", stop_out, stop_seen);
      exp_pc = exp_pc + 32'd4;
    end else begin
      check("idle_inst", inst_IF_out, 32'h0);
      check("idle_pc", PC_out, p_pc);
      check1("idle_stop", stop_out, stop_seen);
    end
    if (imem_req && !p_req) begin
      check("req_addr", imem_addr, exp_req);
      check1("req_after_stop", req_halted, 1'b0);
      if (exp_req == stop_addr) req_halted = 1'b1;
      exp_req = exp_req + 32'd4;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check1({tag, "_req"}, imem_req, 1'b0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_pc"}, PC_out, 32'h0);
    check({tag, "_inst"}, inst_IF_out, 32'h0);
    check1({tag, "_stop"}, stop_out, 1'b0);
    check1({tag, "_valid"}, valid_out, 1'b0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rstn = 1'b1;
    exp_pc = 32'h0; exp_req = 32'h0; stop_seen = 1'b0; req_halted = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(posedge clk);
    #1 check_reset_vals("reset");
    release_reset();
  endtask

  task automatic wait_new_req(input string tag, input logic [31:0] exp_addr);
    logic saw_low, found;
    saw_low = !imem_req; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (!imem_req) saw_low = 1'b1;
      else if (saw_low) found = 1'b1;
    end
    check1({tag, "_seen"}, found, 1'b1);
    if (found) check(tag, imem_addr, exp_addr);
  endtask

  initial begin
    imem_ack = 1'b0; imem_rdata = 32'h0;

    // 1: basic fetch with 1-cycle memory
    do_reset();
    step();
    check("t1_addr0", imem_addr, 32'h0);
    repeat (3) step();
    check("t1_pc0", PC_out, 32'h0);
    check("t1_inst0", inst_IF_out, 32'h0050_0093);
    check1("t1_valid0", valid_out, 1'b1);
    repeat (3) step();
    check("t1_pc1", PC_out, 32'h4);
    check("t1_inst1", inst_IF_out, 32'h0010_0113);
    check1("t1_req8", imem_req, 1'b1);
    check("t1_addr8", imem_addr, 32'h8);

    // 3: redirect while request to 0x8 is outstanding
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    check1("t3_valid", valid_out, 1'b0);
    wait_new_req("t3_addr", 32'h100);
    repeat (6) step();

    // 2: stall fills the queue; 4: stop at 0xC
    do_reset();
    stop_addr = 32'hC;
    repeat (4) step();
    check("t2_first", PC_out, 32'h0);
    stall_in = 1'b1;
    repeat (5) step();
    check("t2_frozen", inst_IF_out, 32'h0050_0093);
    check1("t2_req_idle", imem_req, 1'b0);
    stall_in = 1'b0;
    step();
    check("t2_pc4", PC_out, 32'h4);
    check1("t2_full_noreq", imem_req, 1'b0);
    step();
    check("t2_pc8", PC_out, 32'h8);
    check1("t2_valid8", valid_out, 1'b1);
    for (int i = 0; i < 10 && !(valid_out && PC_out == 32'hC); i++) step();
    check("t4_pc", PC_out, 32'hC);
    check1("t4_stop", stop_out, 1'b1);
    repeat (8) step();
    check1("t4_sticky", stop_out, 1'b1);
    check1("t4_noreq", imem_req, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    check1("t4_stop_clr", stop_out, 1'b0);
    wait_new_req("t4_restart", 32'h0);

    // 5: asynchronous reset mid-transfer
    step();
    #2 rstn = 1'b0;
    #1 check_reset_vals("t5_async");
    release_reset();
    wait_new_req("t5_restart", 32'h0);
    repeat (3) step();

    // 6: misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check1("t6_misalign", misalign_err, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      check1("t6_noreq", imem_req, 1'b0);
    end
`else
    wait_new_req("t6_aligned", 32'h100);
`endif

    // randomized stalls, redirects and memory latency
    do_reset();
    stop_addr = 32'h40;
    rand_lat  = 1'b1;
    for (int i = 0; i < 800; i++) begin
      stall_in       = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = 32'($urandom_range(0, 31)) << 2;
      step();
    end
    redirect_valid = 1'b0;
    stall_in       = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
